// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Brief    : AXI4 responder backed by an on-chip SRAM array. Independent read
//            and write FSMs, FIXED/INCR bursts, byte strobes, programmable
//            read/write latency, DECERR/SLVERR error responses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                MEM_WORDS = 4096,
    parameter int                RD_LAT    = 2,
    parameter int                WR_LAT    = 2
) (
    input  logic                clk,
    input  logic                rst,
    // read address channel
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    // read data channel
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic [ID_W-1:0]     rid,
    output logic                rvalid,
    input  logic                rready,
    // write address channel
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    // write data channel
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    // write response channel
    output logic [1:0]          bresp,
    output logic [ID_W-1:0]     bid,
    output logic                bvalid,
    input  logic                bready
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_LSB    = $clog2(c_STRB_W);
    localparam int c_IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] c_OKAY   = 2'b00;
    localparam logic [1:0] c_SLVERR = 2'b10;
    localparam logic [1:0] c_DECERR = 2'b11;

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_WAIT = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_DATA = 2'd1;
    localparam logic [1:0] c_W_WAIT = 2'd2;
    localparam logic [1:0] c_W_RESP = 2'd3;

    // word offset of a byte address relative to the mapped base
    function automatic logic [ADDR_W-1:0] f_word(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return off >> c_LSB;
    endfunction

    function automatic logic [c_IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return c_IDX_W'(f_word(a));
    endfunction

    // per-beat response; decode error outranks protocol error
    function automatic logic [1:0] f_err(input logic [ADDR_W-1:0] a,
                                         input logic [2:0]        size,
                                         input logic [1:0]        burst);
        if (a < BASE_ADDR || f_word(a) >= ADDR_W'(MEM_WORDS)) return c_DECERR;
        if (burst[1] || size > 3'(c_LSB))                      return c_SLVERR;
        return c_OKAY;
    endfunction

    // FIXED keeps the address, INCR steps by the beat size; WRAP never accesses memory
    function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a,
                                                 input logic [2:0]        size,
                                                 input logic [1:0]        burst);
        return (burst == 2'b01) ? a + (ADDR_W'(1) << size) : a;
    endfunction

    // response codes are ordered by severity, so numeric max picks the worst
    function automatic logic [1:0] f_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // read channel state
    logic [1:0]        r_rstate;
    logic [ADDR_W-1:0] r_raddr;
    logic [ID_W-1:0]   r_rid;
    logic [7:0]        r_rlen;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst;
    logic [7:0]        r_rbeat;
    logic [31:0]       r_rlat;

    // write channel state
    logic [1:0]        r_wstate;
    logic [ADDR_W-1:0] r_waddr;
    logic [ID_W-1:0]   r_bid;
    logic [7:0]        r_wlen;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst;
    logic [7:0]        r_wbeat;
    logic [31:0]       r_wlat;
    logic [1:0]        r_werr;

    logic              w_rvalid;
    logic [1:0]        w_rerr;
    logic [c_IDX_W-1:0] w_ridx;
    logic              w_wfire;
    logic              w_wlastbeat;
    logic              w_wmis;
    logic [1:0]        w_werr;
    logic [1:0]        w_werr_next;
    logic [c_IDX_W-1:0] w_widx;

    assign w_rvalid    = (r_rstate == c_R_DATA);
    assign w_rerr      = f_err(r_raddr, r_rsize, r_rburst);
    assign w_ridx      = f_idx(r_raddr);

    assign w_wfire     = (r_wstate == c_W_DATA) && wvalid;
    assign w_wlastbeat = (r_wbeat == r_wlen);
    assign w_wmis      = wlast ^ w_wlastbeat;
    assign w_werr      = f_err(r_waddr, r_wsize, r_wburst);
    assign w_werr_next = f_max(r_werr, f_max(w_werr, w_wmis ? c_SLVERR : c_OKAY));
    assign w_widx      = f_idx(r_waddr);

    assign arready = (r_rstate == c_R_IDLE);
    assign rvalid  = w_rvalid;
    assign rdata   = (w_rvalid && w_rerr == c_OKAY) ? r_mem[w_ridx] : '0;
    assign rresp   = w_rvalid ? w_rerr : c_OKAY;
    assign rlast   = w_rvalid && (r_rbeat == r_rlen);
    assign rid     = w_rvalid ? r_rid : '0;

    assign awready = (r_wstate == c_W_IDLE);
    assign wready  = (r_wstate == c_W_DATA);
    assign bvalid  = (r_wstate == c_W_RESP);
    assign bresp   = bvalid ? r_werr : c_OKAY;
    assign bid     = bvalid ? r_bid : '0;

    // read FSM: accept AR, wait out the read latency, stream beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= c_R_IDLE;
            r_raddr  <= '0;
            r_rid    <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rbeat  <= '0;
            r_rlat   <= '0;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (arvalid) begin
                        r_raddr  <= araddr;
                        r_rid    <= arid;
                        r_rlen   <= arlen;
                        r_rsize  <= arsize;
                        r_rburst <= arburst;
                        r_rbeat  <= '0;
                        if (RD_LAT == 0) begin
                            r_rstate <= c_R_DATA;
                        end else begin
                            r_rlat   <= 32'(RD_LAT);
                            r_rstate <= c_R_WAIT;
                        end
                    end
                end
                c_R_WAIT: begin
                    r_rlat <= r_rlat - 32'd1;
                    if (r_rlat <= 32'd1) r_rstate <= c_R_DATA;
                end
                c_R_DATA: begin
                    if (rready) begin
                        if (r_rbeat == r_rlen) begin
                            r_rstate <= c_R_IDLE;
                        end else begin
                            r_rbeat <= r_rbeat + 8'd1;
                            r_raddr <= f_next(r_raddr, r_rsize, r_rburst);
                        end
                    end
                end
                default: r_rstate <= c_R_IDLE;
            endcase
        end
    end

    // write FSM: accept AW, absorb beats, wait out the write latency, respond
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= c_W_IDLE;
            r_waddr  <= '0;
            r_bid    <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wbeat  <= '0;
            r_wlat   <= '0;
            r_werr   <= c_OKAY;
        end else begin
            case (r_wstate)
                c_W_IDLE: begin
                    if (awvalid) begin
                        r_waddr  <= awaddr;
                        r_bid    <= awid;
                        r_wlen   <= awlen;
                        r_wsize  <= awsize;
                        r_wburst <= awburst;
                        r_wbeat  <= '0;
                        r_werr   <= c_OKAY;
                        r_wstate <= c_W_DATA;
                    end
                end
                c_W_DATA: begin
                    if (wvalid) begin
                        r_werr  <= w_werr_next;
                        r_wbeat <= r_wbeat + 8'd1;
                        r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
                        // either wlast or the beat count closes the burst
                        if (wlast || w_wlastbeat) begin
                            if (WR_LAT == 0) begin
                                r_wstate <= c_W_RESP;
                            end else begin
                                r_wlat   <= 32'(WR_LAT);
                                r_wstate <= c_W_WAIT;
                            end
                        end
                    end
                end
                c_W_WAIT: begin
                    r_wlat <= r_wlat - 32'd1;
                    if (r_wlat <= 32'd1) r_wstate <= c_W_RESP;
                end
                c_W_RESP: begin
                    if (bready) r_wstate <= c_W_IDLE;
                end
                default: r_wstate <= c_W_IDLE;
            endcase
        end
    end

    // SRAM byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_wfire && w_werr == c_OKAY) begin
            for (int i = 0; i < c_STRB_W; i++) begin
                if (wstrb[i]) r_mem[w_widx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder modelling an on-chip SRAM. It sits behind the IFU/LSU AXI arbiter as the memory endpoint for simulation and bring-up.
- Read and write channels run as independent FSMs. Supports FIXED/INCR bursts, byte strobes, and programmable read/write latency.
- Answers out-of-range addresses with DECERR and unsupported burst types with SLVERR.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (power of two, ≥8)
- ID_W, 4, transaction ID width
- BASE_ADDR, 32'h8000_0000, first byte address mapped
- MEM_WORDS, 4096, SRAM depth in DATA_W words
- RD_LAT, 2, cycles from AR handshake to first rvalid, minus 1 (0 = rvalid the cycle after AR handshake)
- WR_LAT, 2, idle cycles from last W handshake to bvalid, minus 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- araddr  in  ADDR_W  read address
- arid  in  ID_W  read ID
- arlen  in  8  beats-1
- arsize  in  3  log2 bytes/beat
- arburst  in  2  burst type
- arvalid  in  1  / arready  out  1
- rdata  out  DATA_W / rresp  out  2 / rlast  out  1 / rid  out  ID_W / rvalid  out  1 / rready  in  1
- awaddr  in  ADDR_W / awid  in  ID_W / awlen  in  8 / awsize  in  3 / awburst  in  2 / awvalid  in  1 / awready  out  1
- wdata  in  DATA_W / wstrb  in  DATA_W/8 / wlast  in  1 / wvalid  in  1 / wready  out  1
- bresp  out  2 / bid  out  ID_W / bvalid  out  1 / bready  in  1

Behaviour:
- Reset (synchronous, rst=1 at posedge): both FSMs go to IDLE and beat/latency counters clear.
  - Outputs after reset: arready=1, awready=1, rvalid=0, bvalid=0, wready=0, rlast=0, rdata=0, rresp=0, bresp=0, rid=0, bid=0.
  - SRAM contents are not cleared.
  - Reset mid-burst abandons the transaction: no rvalid/bvalid for it, and partial writes already committed remain.
- Read FSM R_IDLE → R_WAIT → R_DATA → R_IDLE:
  - R_IDLE: arready=1. On arvalid&arready, latch addr/id/len/size/burst, set beat=0, lat=RD_LAT, go to R_WAIT.
  - R_WAIT: arready=0. Decrement lat each cycle; when lat==0, go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rdata=mem[word(addr)] combinationally, rlast=(beat==len).
    - All R outputs hold stable while rready=0.
    - On rvalid&rready: if rlast, go to R_IDLE (arready=1 the next cycle; no same-cycle re-accept). Otherwise beat++ and advance the address.
- Write FSM W_IDLE → W_DATA → W_WAIT → W_RESP → W_IDLE:
  - W_IDLE: awready=1, wready=0. On AW handshake, latch fields, set beat=0, err=OKAY, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&wready writes lanes where wstrb[i]=1 at word(addr); then beat++ and advance the address.
    - The burst ends on the handshake where wlast=1 or beat==len.
    - If the two disagree (wlast without beat==len, or beat==len without wlast), bresp=SLVERR and the FSM still ends.
    - Ending the burst loads lat=WR_LAT and goes to W_WAIT.
  - W_WAIT: count lat down to 0, then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp=err; held until bready. Then go to W_IDLE.
- Address advance:
  - FIXED (00): address unchanged.
  - INCR (01): address += 1<<size, 32-bit wrap-around.
  - WRAP (10) and reserved (11): SLVERR for every beat, no SRAM access, and the beat count is still honoured.
- word(addr) = (addr − BASE_ADDR) >> log2(DATA_W/8).
  - Address below BASE_ADDR or word ≥ MEM_WORDS: per-beat DECERR (2'b11), rdata=0, write suppressed.
  - Error priority: DECERR over SLVERR; bresp carries the highest-severity beat.
- Narrow transfers: rdata is always the full aligned word, and the master selects lanes.
- arsize > log2(DATA_W/8) → SLVERR.
- The read and write FSMs are concurrent. A read beat and a write to the same word in the same cycle: the read returns the pre-write data and the write commits at the clock edge.

Test Plan:
- Single read: mem[0]=32'hDEADBEEF; AR addr=0x8000_0000, len=0, size=2, INCR, id=3, RD_LAT=2 → rvalid rises exactly 3 cycles after the AR handshake; rdata=DEADBEEF, rresp=0, rlast=1, rid=3; arready returns high the cycle after the R handshake.
- Burst read with backpressure: len=3 INCR from 0x8000_0010; rready toggles 1,0,0,1,... → 4 beats of mem[4..7] in order; rdata held stable while rready=0; rlast only on beat 4.
- Strobed write: mem[2]=0; AW 0x8000_0008, W wdata=0x11223344, wstrb=4'b0101, wlast=1 → bvalid WR_LAT+1 cycles after the W handshake, bresp=0, bid=awid; a readback returns 0x00220044.
- Write burst with wlast mismatch: len=1, wlast asserted on beat 1 → bresp=SLVERR (2'b10) and beat 1 written; a separate len=1 burst with correct wlast → bresp=0 and both words written.
- Errors:
  - Read of 0x7FFF_FFFC → rresp=DECERR, rdata=0.
  - Write to BASE_ADDR+4*MEM_WORDS → bresp=DECERR, no SRAM change.
  - arburst=WRAP, len=1 → 2 beats with SLVERR.
- Reset mid-operation: assert rst during R_DATA beat 2 of 4 and during W_WAIT → next cycle rvalid=0, bvalid=0, arready=1, awready=1; a fresh read then completes normally.
